ipv4_deparser: RTL

Writes the header fields produced by the IPv4 parser and modified by the match/action stages back into the 480-bit packet header word, and repairs the checksums those edits invalidate. It is the transmit-side counterpart of the parser and sits at the tail of the pipeline, just before the output queues. It is a fixed 3-stage pipeline with no backpressure, one header word per cycle. It also keeps packet and rewrite statistics.

---
 rtl/ipv4_deparser.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ipv4_deparser.sv
// IPv4/TCP header deparser: merges rewritten MAC/IP/port fields into the header word
// and repairs the IPv4 and TCP checksums over a fixed 3-stage pipeline.
module ipv4_deparser #(
   parameter int DATA_WIDTH = 480,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pkt_data_vld_in,
   input  logic [DATA_WIDTH-1:0] pkt_data_in,
   input  logic                  tuple_vld,
   input  logic                  dmac_vld,
   input  logic                  smac_vld,
   input  logic [47:0]           dmac_data,
   input  logic [47:0]           smac_data,
   input  logic                  sip_vld,
   input  logic                  dip_vld,
   input  logic [31:0]           sip_data,
   input  logic [31:0]           dip_data,
   input  logic                  sport_vld,
   input  logic                  dport_vld,
   input  logic [15:0]           sport_data,
   input  logic [15:0]           dport_data,
   output logic                  pkt_data_vld_out,
   output logic [DATA_WIDTH-1:0] pkt_data_out,
   output logic                  ip_csum_upd,
   output logic                  tcp_csum_upd,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  mod_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   function automatic logic [19:0] ext(input logic [15:0] v);
      return {4'd0, v};
   endfunction

   // Two end-around-carry folds are enough for any 20-bit sum of at most 16 terms.
   function automatic logic [15:0] csum_fold(input logic [19:0] s);
      logic [19:0] t;
      t = ext(s[15:0]) + {16'd0, s[19:16]};
      t = ext(t[15:0]) + {16'd0, t[19:16]};
      return ~t[15:0];
   endfunction

   logic                  is_ip, is_tcp;
   logic                  sub_dmac, sub_smac, sub_sip, sub_dip, sub_sport, sub_dport;
   logic [DATA_WIDTH-1:0] word_c;

   always_comb begin
      is_ip     = (pkt_data_in[383:368] == 16'h0800);
      is_tcp    = is_ip && tuple_vld && (pkt_data_in[295:288] == 8'h06);
      sub_dmac  = pkt_data_vld_in && dmac_vld;
      sub_smac  = pkt_data_vld_in && smac_vld;
      sub_sip   = pkt_data_vld_in && is_ip && sip_vld;
      sub_dip   = pkt_data_vld_in && is_ip && dip_vld;
      sub_sport = pkt_data_vld_in && is_tcp && sport_vld;
      sub_dport = pkt_data_vld_in && is_tcp && dport_vld;
      word_c    = pkt_data_in;
      if (sub_dmac)  word_c[479:432] = dmac_data;
      if (sub_smac)  word_c[431:384] = smac_data;
      if (sub_sip)   word_c[271:240] = sip_data;
      if (sub_dip)   word_c[239:208] = dip_data;
      if (sub_sport) word_c[207:192] = sport_data;
      if (sub_dport) word_c[191:176] = dport_data;
   end

   // Stage 1: capture rewritten word plus the original fields the TCP delta needs
   logic                  vld_p0, ip_mod_p0, tcp_mod_p0, any_mod_p0;
   logic [DATA_WIDTH-1:0] word_p0;
   logic [31:0]           sip_old_p0, dip_old_p0;
   logic [15:0]           sport_old_p0, dport_old_p0, tcsum_old_p0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p0       <= 1'b0;
         ip_mod_p0    <= 1'b0;
         tcp_mod_p0   <= 1'b0;
         any_mod_p0   <= 1'b0;
         word_p0      <= '0;
         sip_old_p0   <= '0;
         dip_old_p0   <= '0;
         sport_old_p0 <= '0;
         dport_old_p0 <= '0;
         tcsum_old_p0 <= '0;
      end else begin
         vld_p0       <= pkt_data_vld_in;
         ip_mod_p0    <= sub_sip || sub_dip;
         tcp_mod_p0   <= is_tcp && (sub_sip || sub_dip || sub_sport || sub_dport);
         any_mod_p0   <= sub_dmac || sub_smac || sub_sip || sub_dip || sub_sport || sub_dport;
         word_p0      <= word_c;
         sip_old_p0   <= pkt_data_in[271:240];
         dip_old_p0   <= pkt_data_in[239:208];
         sport_old_p0 <= pkt_data_in[207:192];
         dport_old_p0 <= pkt_data_in[191:176];
         tcsum_old_p0 <= pkt_data_in[79:64];
      end
   end

   logic [19:0] ip_sum_c, tcp_sum_c;

   always_comb begin
      ip_sum_c = '0;
      for (int i = 0; i < 10; i++) begin
         if (i != 5) ip_sum_c = ip_sum_c + ext(word_p0[367-16*i -: 16]);
      end
      // Incremental update: ~HC + sum(~m + m') over every field that may have changed
      tcp_sum_c = ext(~tcsum_old_p0)
                + ext(~sip_old_p0[31:16])  + ext(word_p0[271:256])
                + ext(~sip_old_p0[15:0])   + ext(word_p0[255:240])
                + ext(~dip_old_p0[31:16])  + ext(word_p0[239:224])
                + ext(~dip_old_p0[15:0])   + ext(word_p0[223:208])
                + ext(~sport_old_p0)       + ext(word_p0[207:192])
                + ext(~dport_old_p0)       + ext(word_p0[191:176]);
   end

   // Stage 2: register the raw checksum sums
   logic                  vld_p1, ip_mod_p1, tcp_mod_p1, any_mod_p1;
   logic [DATA_WIDTH-1:0] word_p1;
   logic [19:0]           ip_sum_p1, tcp_sum_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1     <= 1'b0;
         ip_mod_p1  <= 1'b0;
         tcp_mod_p1 <= 1'b0;
         any_mod_p1 <= 1'b0;
         word_p1    <= '0;
         ip_sum_p1  <= '0;
         tcp_sum_p1 <= '0;
      end else begin
         vld_p1     <= vld_p0;
         ip_mod_p1  <= ip_mod_p0;
         tcp_mod_p1 <= tcp_mod_p0;
         any_mod_p1 <= any_mod_p0;
         word_p1    <= word_p0;
         ip_sum_p1  <= ip_sum_c;
         tcp_sum_p1 <= tcp_sum_c;
      end
   end

   logic [DATA_WIDTH-1:0] word_out_c;

   always_comb begin
      word_out_c = word_p1;
      if (ip_mod_p1)  word_out_c[287:272] = csum_fold(ip_sum_p1);
      if (tcp_mod_p1) word_out_c[79:64]   = csum_fold(tcp_sum_p1);
   end

   // Stage 3: fold, insert checksums, count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pkt_data_vld_out <= 1'b0;
         pkt_data_out     <= '0;
         ip_csum_upd      <= 1'b0;
         tcp_csum_upd     <= 1'b0;
         pkt_cnt          <= '0;
         mod_cnt          <= '0;
      end else begin
         pkt_data_vld_out <= vld_p1;
         pkt_data_out     <= word_out_c;
         ip_csum_upd      <= ip_mod_p1;
         tcp_csum_upd     <= tcp_mod_p1;
         if (vld_p1)               pkt_cnt <= pkt_cnt + CNT_ONE;
         if (vld_p1 && any_mod_p1) mod_cnt <= mod_cnt + CNT_ONE;
      end
   end

endmodule
